// File: rtl/fighter_core.sv
// Per-player fighter engine: position, health, KO and hit resolution, one round per step.
// Optional attack cooldown is built when FIGHTER_COOLDOWN_EN is defined.
module fighter_core #(
  parameter int unsigned SIDE        = 0,
  parameter int unsigned NUM_POS     = 8,
  parameter int unsigned POS_W       = 3,
  parameter int unsigned HEALTH_W    = 2,
  parameter int unsigned KICK_DMG    = 1,
  parameter int unsigned PUNCH_DMG   = 2,
  parameter int unsigned KICK_REACH  = 2,
  parameter int unsigned PUNCH_REACH = 1,
  parameter int unsigned COOLDOWN    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                step,
  input  logic [2:0]          action,
  input  logic [2:0]          opp_action,
  input  logic [POS_W-1:0]    opp_pos,
  output logic [POS_W-1:0]    pos,
  output logic [HEALTH_W-1:0] health,
  output logic                ko,
  output logic                hit,
  output logic [2:0]          eff_action
);

  localparam int unsigned PW = POS_W + 1;
  localparam logic [2:0] A_KICK  = 3'b000;
  localparam logic [2:0] A_PUNCH = 3'b001;
  localparam logic [2:0] A_JUMP  = 3'b011;
  localparam logic [PW-1:0] LAST = PW'(NUM_POS - 1);
  localparam logic [POS_W-1:0] HOME = (SIDE == 0) ? POS_W'(0) : POS_W'(NUM_POS - 1);
  localparam logic [HEALTH_W-1:0] MAX_HEALTH = '1;

  if (SIDE > 1 || NUM_POS < 3 || NUM_POS > (1 << POS_W) || COOLDOWN > 255) begin : g_bad_params
    $error("fighter_core: illegal parameter combination");
  end

  logic [PW-1:0]       p, d, mv, cap, amt, pos_mv, pos_kb;
  logic                fwd, kick_in, punch_in, take_hit, kick_hit;
  logic [31:0]         dmg;
  logic [POS_W-1:0]    pos_d;
  logic [HEALTH_W-1:0] health_d;

  // Round resolution: incoming hit, damage, knockback or own movement.
  always_comb begin
    p        = PW'(pos);
    d        = (PW'(opp_pos) > p) ? PW'(opp_pos) - p : p - PW'(opp_pos);
    kick_in  = (opp_action == A_KICK)  && (32'(d) <= KICK_REACH);
    punch_in = (opp_action == A_PUNCH) && (32'(d) <= PUNCH_REACH);
    take_hit = (kick_in || punch_in) && (action != A_JUMP);
    kick_hit = take_hit && kick_in;
    dmg      = kick_hit ? 32'(KICK_DMG) : 32'(PUNCH_DMG);

    health_d = health;
    if (take_hit) begin
      health_d = (32'(health) > dmg) ? HEALTH_W'(32'(health) - dmg) : '0;
    end

    // Forward steps are capped at half the gap so simultaneous advances never collide.
    mv  = action[0] ? PW'(2) : PW'(1);
    cap = (d - PW'(1)) >> 1;
    fwd = (action[1] == (SIDE == 0));
    amt = (fwd && (cap < mv)) ? cap : mv;

    pos_mv = p;
    if (action[2]) begin
      if (action[1]) begin
        pos_mv = ((p + amt) > LAST) ? LAST : p + amt;
      end else begin
        pos_mv = (p > amt) ? p - amt : '0;
      end
    end

    if (SIDE == 0) begin
      pos_kb = (p != '0) ? p - PW'(1) : p;
    end else begin
      pos_kb = (p < LAST) ? p + PW'(1) : p;
    end

    pos_d = POS_W'(kick_hit ? pos_kb : pos_mv);
  end

`ifdef FIGHTER_COOLDOWN_EN
  localparam int unsigned CNT_W = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [2:0] A_AWAIT = 3'b010;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Attacks are turned into await while the lockout counter runs.
  always_comb begin
    eff_action = action;
    if ((cnt_q != '0) && ((action == A_KICK) || (action == A_PUNCH))) begin
      eff_action = A_AWAIT;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (step && !ko) begin
      if ((eff_action == A_KICK) || (eff_action == A_PUNCH)) begin
        cnt_d = CNT_W'(COOLDOWN);
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign eff_action = action;
`endif

  // Fighter state; frozen once knocked out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos    <= HOME;
      health <= MAX_HEALTH;
      ko     <= 1'b0;
      hit    <= 1'b0;
    end else if (step && !ko) begin
      pos    <= pos_d;
      health <= health_d;
      ko     <= (health_d == '0);
      hit    <= take_hit;
    end else begin
      hit    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fighter_core.sv
// Bench for fighter_core: one instance per side, driven directly and checked against a round model.
`timescale 1ns/1ps
module tb_fighter_core;

  localparam int NP   = 8;
  localparam int MAXH = 3;
  localparam logic [2:0] KICK   = 3'b000;
  localparam logic [2:0] PUNCH  = 3'b001;
  localparam logic [2:0] AWAIT  = 3'b010;
  localparam logic [2:0] JUMP   = 3'b011;
  localparam logic [2:0] RIGHT1 = 3'b110;
  localparam logic [2:0] RIGHT2 = 3'b111;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       step  = 1'b0;
  logic [2:0] act  [2];
  logic [2:0] oact [2];
  logic [2:0] opos [2];
  logic [2:0] pos  [2];
  logic [1:0] health [2];
  logic       ko   [2];
  logic       hit  [2];
  logic [2:0] eff  [2];

  fighter_core #(.SIDE(0)) u_left (
    .clk(clk), .rst_n(rst_n), .step(step), .action(act[0]), .opp_action(oact[0]),
    .opp_pos(opos[0]), .pos(pos[0]), .health(health[0]), .ko(ko[0]), .hit(hit[0]),
    .eff_action(eff[0])
  );

  fighter_core #(.SIDE(1)) u_right (
    .clk(clk), .rst_n(rst_n), .step(step), .action(act[1]), .opp_action(oact[1]),
    .opp_pos(opos[1]), .pos(pos[1]), .health(health[1]), .ko(ko[1]), .hit(hit[1]),
    .eff_action(eff[1])
  );

  always #5 clk = ~clk;

  // Round model in plain integer arithmetic.
  int mpos [2];
  int mhp  [2];
  int mcnt [2];
  bit mko  [2];
  bit mhit [2];

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  function automatic void check(string name, int s, int got, int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s side%0d: got %0d expected %0d at %0t", name, s, got, exp, $time);
  endfunction

  function automatic logic [2:0] m_eff(logic [2:0] a, int c);
`ifdef FIGHTER_COOLDOWN_EN
    if (c > 0 && (a == KICK || a == PUNCH)) return AWAIT;
`endif
    return a;
  endfunction

  function automatic void m_reset();
    for (int s = 0; s < 2; s++) begin
      mpos[s] = (s == 0) ? 0 : NP - 1;
      mhp[s]  = MAXH;
      mcnt[s] = 0;
      mko[s]  = 1'b0;
      mhit[s] = 1'b0;
    end
  endfunction

  function automatic void m_round(int s);
    int d, n, np;
    logic [2:0] a, e;
    bit kin, pun, struck;
    mhit[s] = 1'b0;
    if (!step || mko[s]) return;
    a = act[s];
    e = m_eff(a, mcnt[s]);
    d = int'(opos[s]) - mpos[s];
    if (d < 0) d = -d;
    kin    = (oact[s] == KICK) && (d <= 2);
    pun    = (oact[s] == PUNCH) && (d <= 1);
    struck = (kin || pun) && (a != JUMP);
    np = mpos[s];
    if (struck) begin
      mhp[s] = mhp[s] - (kin ? 1 : 2);
      if (mhp[s] < 0) mhp[s] = 0;
      mhit[s] = 1'b1;
    end
    if (struck && kin) begin
      np = (s == 0) ? np - 1 : np + 1;
    end else if (a[2]) begin
      n = a[0] ? 2 : 1;
      if (a[1] == (s == 0)) n = (n < (d - 1) / 2) ? n : (d - 1) / 2;
      np = a[1] ? np + n : np - n;
    end
    mpos[s] = (np < 0) ? 0 : ((np > NP - 1) ? NP - 1 : np);
    if (e == KICK || e == PUNCH) mcnt[s] = 2;
    else if (mcnt[s] > 0) mcnt[s]--;
    if (mhp[s] == 0) mko[s] = 1'b1;
  endfunction

  // Every falling edge: all outputs of both fighters against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int s = 0; s < 2; s++) begin
        check("pos", s, int'(pos[s]), mpos[s]);
        check("health", s, int'(health[s]), mhp[s]);
        check("ko", s, int'(ko[s]), int'(mko[s]));
        check("hit", s, int'(hit[s]), int'(mhit[s]));
        check("eff_action", s, int'(eff[s]), int'(m_eff(act[s], mcnt[s])));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      m_round(0);
      m_round(1);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] a0, input logic [2:0] o0, input int p0);
    step    = 1'b1;
    act[0]  = a0;
    oact[0] = o0;
    opos[0] = 3'(p0);
    act[1]  = AWAIT;
    oact[1] = AWAIT;
    opos[1] = 3'd0;
  endtask

  // Reset asserted a few ns after a clock edge; outputs must drop before the next edge.
  task automatic do_reset();
    step = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    m_reset();
    #1;
    for (int s = 0; s < 2; s++) begin
      check("rst_pos", s, int'(pos[s]), (s == 0) ? 0 : 7);
      check("rst_health", s, int'(health[s]), 3);
      check("rst_ko", s, int'(ko[s]), 0);
      check("rst_hit", s, int'(hit[s]), 0);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] cd_exp [4];
    int r;
    for (int s = 0; s < 2; s++) begin
      act[s]  = AWAIT;
      oact[s] = AWAIT;
      opos[s] = (s == 0) ? 3'd7 : 3'd0;
    end
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Advance with forward cap.
    do_reset();
    drive(RIGHT2, AWAIT, 7); tick(); check("adv1", 0, int'(pos[0]), 2);
    drive(RIGHT2, AWAIT, 7); tick(); check("adv2", 0, int'(pos[0]), 4);
    drive(RIGHT2, AWAIT, 7); tick(); check("adv3_capped", 0, int'(pos[0]), 5);

    // Kick knockback overrides own move.
    do_reset();
    drive(RIGHT2, AWAIT, 7); tick();
    drive(RIGHT1, AWAIT, 7); tick(); check("pre_kick_pos", 0, int'(pos[0]), 3);
    drive(RIGHT1, KICK, 5);  tick();
    check("kick_health", 0, int'(health[0]), 2);
    check("kick_hit", 0, int'(hit[0]), 1);
    check("kick_knockback", 0, int'(pos[0]), 2);
    drive(AWAIT, AWAIT, 5);  tick(); check("hit_pulse_end", 0, int'(hit[0]), 0);

    // Jump dodge, punch damage, saturation to KO, then freeze.
    do_reset();
    drive(RIGHT2, AWAIT, 7); tick();
    drive(RIGHT2, AWAIT, 7); tick();
    drive(JUMP, PUNCH, 5);   tick();
    check("dodge_health", 0, int'(health[0]), 3);
    check("dodge_hit", 0, int'(hit[0]), 0);
    drive(AWAIT, PUNCH, 5);  tick();
    check("punch_health", 0, int'(health[0]), 1);
    check("punch_pos", 0, int'(pos[0]), 4);
    drive(AWAIT, PUNCH, 5);  tick();
    check("sat_health", 0, int'(health[0]), 0);
    check("sat_ko", 0, int'(ko[0]), 1);
    repeat (2) begin
      drive(RIGHT1, KICK, 5); tick();
      check("frozen_pos", 0, int'(pos[0]), 4);
      check("frozen_health", 0, int'(health[0]), 0);
      check("frozen_hit", 0, int'(hit[0]), 0);
    end

    // Attack lockout on repeated kicks.
    do_reset();
`ifdef FIGHTER_COOLDOWN_EN
    cd_exp = '{KICK, AWAIT, AWAIT, KICK};
`else
    cd_exp = '{KICK, KICK, KICK, KICK};
`endif
    for (int i = 0; i < 4; i++) begin
      drive(KICK, AWAIT, 7);
      #1;
      check("cooldown_eff", 0, int'(eff[0]), int'(cd_exp[i]));
      tick();
    end

    // Randomized play on both sides with occasional mid-game resets.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        do_reset();
      end else begin
        step = ($urandom_range(0, 9) != 0);
        for (int s = 0; s < 2; s++) begin
          act[s]  = 3'($urandom_range(0, 7));
          oact[s] = 3'($urandom_range(0, 7));
          r = $urandom_range(0, 3);
          if (s == 0) opos[s] = 3'((mpos[0] + 1 + r > NP - 1) ? NP - 1 : mpos[0] + 1 + r);
          else        opos[s] = 3'((mpos[1] - 1 - r < 0) ? 0 : mpos[1] - 1 - r);
        end
        tick();
      end
    end

    do_reset();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
